// File: rtl/pipe_stage_fifo_pkg.sv
// Shared constants for the elastic pipeline-stage buffer: default and legal depth range.
package pipe_stage_fifo_pkg;

  localparam int PIPE_DEPTH_DEFAULT = 2;
  localparam int PIPE_DEPTH_MIN     = 2;
  localparam int PIPE_DEPTH_MAX     = 8;

  function automatic bit depth_legal(input int d);
    return (d >= PIPE_DEPTH_MIN) && (d <= PIPE_DEPTH_MAX);
  endfunction

endpackage

// File: rtl/pipe_stage_fifo_mem.sv
// DEPTH x WIDTH flop array, one synchronous write port, asynchronous read; contents never reset.
module pipe_stage_fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pipe_stage_fifo.sv
// Elastic DEPTH-entry pipeline register, 1-cycle latency, in_ready decoded from registered count only
// (full refuses push even when popping); optional perf counters under PIPE_STAGE_PERF_EN.
module pipe_stage_fifo
  import pipe_stage_fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = PIPE_DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]                stall_cnt,
  output logic [31:0]                drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH-1);

  if (!depth_legal(DEPTH)) begin : g_depth_err
    $error("pipe_stage_fifo: DEPTH must be within 2..8");
  end

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  logic [WIDTH-1:0] head_data;

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;
  assign out_data  = out_valid ? head_data : '0;

  // Non-power-of-two depths need an explicit wrap compare rather than natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  pipe_stage_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push && !flush),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_ptr_q),
    .rdata (head_data)
  );

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] drop_q, drop_d;
  logic [32:0] drop_sum;

  assign drop_sum = {1'b0, drop_q} + 33'(count_q);

  always_comb begin
    stall_d = stall_q;
    drop_d  = drop_q;
    if (out_valid && !out_ready && !flush && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
    if (flush) begin
      drop_d = drop_sum[32] ? '1 : drop_sum[31:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      drop_q  <= '0;
    end else begin
      stall_q <= stall_d;
      drop_q  <= drop_d;
    end
  end

  assign stall_cnt = stall_q;
  assign drop_cnt  = drop_q;
`endif

endmodule
